// File: rtl/gpr_file_pkg.sv
// Shared constants and types for the general-purpose register file.
// Imported by gpr_file and gpr_read_port.
package gpr_file_pkg;

   localparam int unsigned GPR_DATA_W    = 32;
   localparam int unsigned GPR_ADDR_W    = 5;
   localparam int unsigned GPR_ZERO_ADDR = 0;

   typedef logic [GPR_ADDR_W-1:0] gpr_addr_t;

endpackage

// File: rtl/gpr_read_port.sv
// One combinational GPR read port: zero register, WB bypass and
// busy masking for a register being written back this cycle.
module gpr_read_port
   import gpr_file_pkg::*;
#(
   parameter int unsigned DATA_W = GPR_DATA_W,
   parameter int unsigned ADDR_W = GPR_ADDR_W
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              mem_busy,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_waddr,
   input  logic [DATA_W-1:0] wb_wdata,
   output logic [DATA_W-1:0] data,
   output logic              busy
);

   logic nz;
   logic hit;

   assign nz  = (addr != ADDR_W'(GPR_ZERO_ADDR));
   assign hit = nz && wb_we && (wb_waddr == addr);

   always_comb begin
      data = '0;
      unique case (1'b1)
         !nz:     data = '0;
         hit:     data = wb_wdata;
         default: data = mem_data;
      endcase
   end

   // Bypassed data is already current, so the register is not busy.
   assign busy = nz && mem_busy && !hit;

endmodule

// File: rtl/gpr_file.sv
// 32x32 register file with WB-to-ID bypass and busy scoreboard.
// Define GPR_DEBUG_READ_EN for a third (debug/trace) read port.
module gpr_file
   import gpr_file_pkg::*;
#(
   parameter int unsigned DATA_W = GPR_DATA_W,
   parameter int unsigned ADDR_W = GPR_ADDR_W
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              i_WB_GPR_we,
   input  logic [ADDR_W-1:0] i_WB_GPR_waddr,
   input  logic [DATA_W-1:0] i_WB_GPR_wdata,
   input  logic [ADDR_W-1:0] i_ID_rs_addr,
   input  logic [ADDR_W-1:0] i_ID_rt_addr,
   output logic [DATA_W-1:0] o_ID_rs_data,
   output logic [DATA_W-1:0] o_ID_rt_data,
   input  logic              i_ID_issue_we,
   input  logic [ADDR_W-1:0] i_ID_issue_waddr,
   output logic              o_ID_rs_busy,
`ifdef GPR_DEBUG_READ_EN
   output logic              o_ID_rt_busy,
   input  logic [ADDR_W-1:0] i_DBG_raddr,
   output logic [DATA_W-1:0] o_DBG_rdata
`else
   output logic              o_ID_rt_busy
`endif
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic              wb_en;
   logic              iss_en;

   assign wb_en  = i_WB_GPR_we &&
                   (i_WB_GPR_waddr != ADDR_W'(GPR_ZERO_ADDR));
   assign iss_en = i_ID_issue_we &&
                   (i_ID_issue_waddr != ADDR_W'(GPR_ZERO_ADDR));

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (wb_en) begin
         regs[i_WB_GPR_waddr] <= i_WB_GPR_wdata;
      end
   end

   // Issue is applied after write-back so the younger writer wins.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         busy <= '0;
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            if (iss_en && (i_ID_issue_waddr == ADDR_W'(i)))
               busy[i] <= 1'b1;
            else if (wb_en && (i_WB_GPR_waddr == ADDR_W'(i)))
               busy[i] <= 1'b0;
         end
         busy[0] <= 1'b0;
      end
   end

   gpr_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs (
      .addr     (i_ID_rs_addr),
      .mem_data (regs[i_ID_rs_addr]),
      .mem_busy (busy[i_ID_rs_addr]),
      .wb_we    (i_WB_GPR_we),
      .wb_waddr (i_WB_GPR_waddr),
      .wb_wdata (i_WB_GPR_wdata),
      .data     (o_ID_rs_data),
      .busy     (o_ID_rs_busy)
   );

   gpr_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rt (
      .addr     (i_ID_rt_addr),
      .mem_data (regs[i_ID_rt_addr]),
      .mem_busy (busy[i_ID_rt_addr]),
      .wb_we    (i_WB_GPR_we),
      .wb_waddr (i_WB_GPR_waddr),
      .wb_wdata (i_WB_GPR_wdata),
      .data     (o_ID_rt_data),
      .busy     (o_ID_rt_busy)
   );

`ifdef GPR_DEBUG_READ_EN
   gpr_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dbg (
      .addr     (i_DBG_raddr),
      .mem_data (regs[i_DBG_raddr]),
      .mem_busy (busy[i_DBG_raddr]),
      .wb_we    (i_WB_GPR_we),
      .wb_waddr (i_WB_GPR_waddr),
      .wb_wdata (i_WB_GPR_wdata),
      .data     (o_DBG_rdata),
      .busy     ()
   );
`endif

endmodule

// File: tb/tb_gpr_file.sv
// Bench for gpr_file: directed scenarios plus random traffic
// compared against an array-based reference model.
module tb_gpr_file;

   logic        clk = 1'b0;
   logic        resetn;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        iwe;
   logic [4:0]  iaddr;
   logic        rs_busy;
   logic        rt_busy;
`ifdef GPR_DEBUG_READ_EN
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;
`endif

   logic [31:0] m_reg [32];
   bit          m_busy [32];
   bit          armed;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   gpr_file dut (
      .clk              (clk),
      .resetn           (resetn),
      .i_WB_GPR_we      (we),
      .i_WB_GPR_waddr   (waddr),
      .i_WB_GPR_wdata   (wdata),
      .i_ID_rs_addr     (rs),
      .i_ID_rt_addr     (rt),
      .o_ID_rs_data     (rs_data),
      .o_ID_rt_data     (rt_data),
      .i_ID_issue_we    (iwe),
      .i_ID_issue_waddr (iaddr),
      .o_ID_rs_busy     (rs_busy),
`ifdef GPR_DEBUG_READ_EN
      .o_ID_rt_busy     (rt_busy),
      .i_DBG_raddr      (dbg_addr),
      .o_DBG_rdata      (dbg_data)
`else
      .o_ID_rt_busy     (rt_busy)
`endif
   );

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_data(logic [4:0] a);
      if (a == 0) return 32'h0;
      if (we && waddr == a) return wdata;
      return m_reg[a];
   endfunction

   function automatic logic exp_busy(logic [4:0] a);
      return (a != 0) && m_busy[a] && !(we && waddr == a);
   endfunction

   task automatic model_edge();
      if (!resetn) begin
         for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 0;
         end
      end else begin
         if (we && waddr != 0) begin
            m_reg[waddr]  = wdata;
            m_busy[waddr] = 0;
         end
         if (iwe && iaddr != 0) m_busy[iaddr] = 1;
      end
   endtask

   task automatic cycle();
      #1;
      if (armed) begin
         chk("rs_data", rs_data, exp_data(rs));
         chk("rt_data", rt_data, exp_data(rt));
         chk("rs_busy", 32'(rs_busy), 32'(exp_busy(rs)));
         chk("rt_busy", 32'(rt_busy), 32'(exp_busy(rt)));
`ifdef GPR_DEBUG_READ_EN
         chk("dbg_data", dbg_data, exp_data(dbg_addr));
`endif
      end
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      resetn = 1'b1;
      we     = 1'b0;
      iwe    = 1'b0;
   endtask

   initial begin
      armed  = 0;
      resetn = 1'b0;
      we = 1'b0; waddr = '0; wdata = '0;
      iwe = 1'b0; iaddr = '0;
      rs = '0; rt = '0;
`ifdef GPR_DEBUG_READ_EN
      dbg_addr = '0;
`endif
      @(negedge clk);
      cycle();
      armed = 1;

      // reset clears state
      idle(); we = 1; waddr = 5; wdata = 32'hDEADBEEF;
      iwe = 1; iaddr = 5;
      cycle();
      idle(); rs = 5;
      #1 chk("r5_written", rs_data, 32'hDEADBEEF);
      cycle();
      resetn = 0;
      cycle();
      idle(); rs = 5;
      #1 chk("rst_r5", rs_data, 32'h0);
      chk("rst_busy", 32'(rs_busy), 32'h0);
      cycle();

      // zero register
      idle(); we = 1; waddr = 0; wdata = 32'h12345678;
      iwe = 1; iaddr = 0;
      cycle();
      idle(); rs = 0;
      #1 chk("r0_data", rs_data, 32'h0);
      chk("r0_busy", 32'(rs_busy), 32'h0);
      cycle();

      // bypass
      idle(); we = 1; waddr = 7; wdata = 32'hA5A5A5A5; rs = 7; rt = 7;
      #1 chk("byp_rs", rs_data, 32'hA5A5A5A5);
      chk("byp_rt", rt_data, 32'hA5A5A5A5);
      cycle();
      idle();
      #1 chk("stor_rs", rs_data, 32'hA5A5A5A5);
      chk("stor_rt", rt_data, 32'hA5A5A5A5);
      cycle();

      // scoreboard lifecycle
      idle(); iwe = 1; iaddr = 9;
      cycle();
      idle(); rs = 9;
      #1 chk("sb_busy", 32'(rs_busy), 32'h1);
      cycle();
      idle(); we = 1; waddr = 9; wdata = 32'h0BADF00D; rs = 9;
      #1 chk("sb_wb_busy", 32'(rs_busy), 32'h0);
      chk("sb_wb_data", rs_data, 32'h0BADF00D);
      cycle();
      idle();
      #1 chk("sb_after", 32'(rs_busy), 32'h0);
      cycle();

      // simultaneous set and clear
      idle(); iwe = 1; iaddr = 3;
      cycle();
      idle(); we = 1; waddr = 3; wdata = 32'h33334444;
      iwe = 1; iaddr = 3;
      cycle();
      idle(); rs = 3;
      #1 chk("sim_busy", 32'(rs_busy), 32'h1);
      chk("sim_data", rs_data, 32'h33334444);
      cycle();

`ifdef GPR_DEBUG_READ_EN
      idle(); we = 1; waddr = 31; wdata = 32'hCAFEF00D;
      cycle();
      idle(); dbg_addr = 31;
      #1 chk("dbg_r31", dbg_data, 32'hCAFEF00D);
      cycle();
      dbg_addr = 0;
      #1 chk("dbg_r0", dbg_data, 32'h0);
      cycle();
`endif

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         resetn = ($urandom_range(0, 79) != 0);
         we     = $urandom_range(0, 1);
         waddr  = 5'($urandom_range(0, 31));
         wdata  = $urandom;
         iwe    = $urandom_range(0, 1);
         iaddr  = 5'($urandom_range(0, 31));
         rs     = ($urandom_range(0, 3) == 0) ? waddr :
                  5'($urandom_range(0, 31));
         rt     = ($urandom_range(0, 3) == 0) ? rs :
                  5'($urandom_range(0, 31));
`ifdef GPR_DEBUG_READ_EN
         dbg_addr = 5'($urandom_range(0, 31));
`endif
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gpr_file.md
Name: gpr_file

Overview:
- 32 x 32-bit general-purpose register file. It is the write-back consumer of the MEM/WB pipeline register.
- Accepts the WB-stage write (we/waddr/wdata) and serves two combinational read ports to the ID stage.
- Internal WB-to-ID bypass: a same-cycle write is visible on the read ports.
- Per-register busy scoreboard, set on ID issue and cleared on WB write, used by the hazard unit for stall decisions.

Parameters:
- DATA_W, 32, register width.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- i_WB_GPR_we  in  1  write enable from the MEM/WB register (already gated by its enable).
- i_WB_GPR_waddr  in  ADDR_W  write address.
- i_WB_GPR_wdata  in  DATA_W  write data.
- i_ID_rs_addr  in  ADDR_W  read port A address.
- i_ID_rt_addr  in  ADDR_W  read port B address.
- o_ID_rs_data  out  DATA_W  read port A data.
- o_ID_rt_data  out  DATA_W  read port B data.
- i_ID_issue_we  in  1  issuing instruction will write a GPR.
- i_ID_issue_waddr  in  ADDR_W  destination of the issuing instruction.
- o_ID_rs_busy  out  1  rs has an outstanding write.
- o_ID_rt_busy  out  1  rt has an outstanding write.

Behaviour:
- Reset:
  - All 32 registers clear to 0 on the first clock edge with resetn=0.
  - All busy bits clear on the same edge.
  - Read outputs then reflect 0 combinationally.
  - Writes and issues presented during reset are ignored.
- Register 0:
  - Reads always return 0.
  - Writes to address 0 are dropped.
  - Busy bit 0 is never set; o_*_busy for address 0 is always 0.
- Write: when i_WB_GPR_we=1 and waddr!=0, regs[waddr] <= wdata at the rising edge. Latency 1 cycle to storage.
- Read:
  - Combinational, 0-cycle latency.
  - Bypass: if we=1, waddr!=0 and waddr==read address, output is i_WB_GPR_wdata, not stored data.
  - Both ports bypass independently; rs==rt is legal.
- Scoreboard (one busy bit per register 1..31):
  - Set at the edge when i_ID_issue_we=1 and issue_waddr!=0.
  - Cleared at the edge when i_WB_GPR_we=1 for that address.
  - Simultaneous set and clear on the same address: set wins (the issuing instruction is younger).
  - Set and clear on different addresses apply independently.
  - Set on an already-busy register keeps it at 1. No counting; the single-issue in-order pipeline never has two writers in flight beyond that case.
- Busy outputs:
  - o_ID_rs_busy = busy[rs_addr] & ~(WB write to rs_addr this cycle); same rule for rt.
  - The data is bypassed that cycle, so a register being written is not reported busy.
- Clear on a register that is not busy: no effect, no error.

Optional Feature:
- Macro GPR_DEBUG_READ_EN.
- Defined: adds ports i_DBG_raddr (in, ADDR_W) and o_DBG_rdata (out, DATA_W).
  - Third combinational read port with the same zero and bypass rules.
  - Used by the trace/difftest harness.
- Undefined: ports absent; no extra logic.

Decomposition:
- Shared package holds:
  - GPR_DATA_W = 32.
  - GPR_ADDR_W = 5.
  - GPR_ZERO_ADDR = 0.
  - Type gpr_addr_t.
- One natural sub-module, gpr_read_port. It encapsulates the zero-check plus bypass mux plus busy masking, and is instantiated twice (three times with GPR_DEBUG_READ_EN).
- Storage and scoreboard stay in gpr_file.

Test Plan:
- Reset clears state: after writing r5=0xDEADBEEF, assert resetn=0 for one edge -> rs_addr=5 reads 0x00000000; o_ID_rs_busy=0.
- Zero register: write r0=0x12345678 with we=1 -> reading r0 returns 0; issue_waddr=0 -> o_ID_rs_busy for r0 stays 0.
- Bypass: same cycle we=1, waddr=7, wdata=0xA5A5A5A5, rs=rt=7 -> both outputs 0xA5A5A5A5 combinationally. Next cycle with we=0 -> still 0xA5A5A5A5 from storage.
- Scoreboard lifecycle:
  - Issue waddr=9 -> next cycle rs=9 gives busy=1.
  - During the WB write to 9: busy=0 and data is bypassed.
  - Following cycle: busy=0.
- Simultaneous set/clear: WB writes r3 and ID issues r3 on the same edge -> r3 busy=1 afterwards and storage holds the WB data.
- Debug port (GPR_DEBUG_READ_EN defined): write r31=0xCAFEF00D -> i_DBG_raddr=31 returns 0xCAFEF00D; i_DBG_raddr=0 returns 0.
